trng_ctrl: RTL and testbench

Sequencing and post-processing controller for the free-running inverter-ring entropy source. It enables the oscillator, synchronises and decimates its raw output, and applies von Neumann debiasing. It runs a repetition-count health test and packs debiased bits into bytes, delivered over a valid/ready interface. It sits between the ring oscillator macro and the design's user I/O or register logic.

---
 rtl/trng_ctrl_if.sv | 22 ++
 rtl/trng_ctrl.sv | 221 ++++++++++++++++++++++
 tb/tb_trng_ctrl.sv | 229 ++++++++++++++++++++++
 3 files changed

// File: rtl/trng_ctrl_if.sv
// Output handshake bundle for the TRNG controller.
//   rnd_byte  : debiased random byte, driven by the controller
//   rnd_valid : rnd_byte holds an unconsumed byte, driven by the controller
//   rd_ready  : consumer can accept rnd_byte this cycle, driven by the consumer
// master = byte producer (trng_ctrl), slave = byte consumer.
interface trng_ctrl_if;
  logic [7:0] rnd_byte;
  logic       rnd_valid;
  logic       rd_ready;

  modport master (
    output rnd_byte,
    output rnd_valid,
    input  rd_ready
  );

  modport slave (
    input  rnd_byte,
    input  rnd_valid,
    output rd_ready
  );
endinterface

// File: rtl/trng_ctrl.sv
// Sequencing and post-processing controller for a free-running ring-oscillator
// entropy source.
// It performs these steps:
//   - enables the oscillator
//   - synchronises its raw output
//   - decimates it with a programmable divider
//   - applies von Neumann debiasing
//   - runs a repetition-count health test
//   - packs debiased bits into bytes
// Ports:
//   clk         : system clock, rising edge
//   rst_n       : synchronous active-low reset
//   ena         : block enable, low forces IDLE and clears the datapath
//   osc_raw     : asynchronous ring-oscillator output
//   sample_div  : sample period minus one, in clk cycles
//   osc_en      : oscillator enable, high in every state except IDLE
//   health_fail : sticky repetition-test failure flag
//   rd_if       : byte output handshake (rnd_byte / rnd_valid / rd_ready)
module trng_ctrl #(
  parameter int DIV_W     = 8,
  parameter int REP_LIMIT = 32,
  parameter int WARMUP    = 64
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             ena,
  input  logic             osc_raw,
  input  logic [DIV_W-1:0] sample_div,
  output logic             osc_en,
  output logic             health_fail,
  trng_ctrl_if.master      rd_if
);

  localparam int WARM_W = (WARMUP > 1) ? $clog2(WARMUP) : 1;
  localparam int REP_W  = $clog2(REP_LIMIT + 1);
  localparam logic [WARM_W-1:0] WARM_LAST = WARM_W'(WARMUP - 1);
  localparam logic [REP_W-1:0]  REP_MAX   = REP_W'(REP_LIMIT);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_WARMUP,
    ST_RUN,
    ST_FAIL
  } state_t;

  state_t            state_q, state_d;
  logic [1:0]        sync_q, sync_d;
  logic [WARM_W-1:0] warm_q, warm_d;
  logic [DIV_W-1:0]  div_q, div_d;
  logic [REP_W-1:0]  rep_q, rep_d;
  logic              prev_q, prev_d;
  logic              phase_q, phase_d;
  logic              first_q, first_d;
  logic [7:0]        shift_q, shift_d;
  logic [3:0]        cnt_q, cnt_d;
  logic [7:0]        byte_q, byte_d;
  logic              valid_q, valid_d;
  logic              health_q, health_d;

  logic              sample;
  logic              strobe;
  logic [REP_W-1:0]  rep_next;
  logic [7:0]        shift_tmp;
  logic [3:0]        cnt_tmp;

  // Second synchroniser stage is the only view of the oscillator the logic uses.
  assign sample = sync_q[1];

  // Next-state logic. The ena-low override sits last so it wins over
  // everything, and a health trip is evaluated after the byte transfer
  // so it discards any byte completing on the same edge.
  always_comb begin
    state_d   = state_q;
    sync_d    = {sync_q[0], osc_raw};
    warm_d    = warm_q;
    div_d     = div_q;
    rep_d     = rep_q;
    prev_d    = prev_q;
    phase_d   = phase_q;
    first_d   = first_q;
    shift_d   = shift_q;
    cnt_d     = cnt_q;
    byte_d    = byte_q;
    valid_d   = valid_q;
    health_d  = health_q;
    strobe    = 1'b0;
    rep_next  = rep_q;
    shift_tmp = shift_q;
    cnt_tmp   = cnt_q;

    case (state_q)
      ST_IDLE: begin
        if (ena) begin
          state_d = ST_WARMUP;
          warm_d  = '0;
        end
      end

      ST_WARMUP: begin
        warm_d = warm_q + 1'b1;
        if (warm_q == WARM_LAST) begin
          state_d = ST_RUN;
          div_d   = sample_div;
          rep_d   = '0;
          phase_d = 1'b0;
        end
      end

      ST_RUN: begin
        if (div_q == '0) begin
          strobe = 1'b1;
          div_d  = sample_div;
        end else begin
          div_d = div_q - 1'b1;
        end

        if (valid_q && rd_if.rd_ready) begin
          valid_d = 1'b0;
        end

        if (strobe) begin
          // rep_q == 0 marks "no sample yet since RUN entry".
          if (rep_q == '0 || sample != prev_q) begin
            rep_next = REP_W'(1);
          end else begin
            rep_next = rep_q + 1'b1;
          end
          rep_d  = rep_next;
          prev_d = sample;

          if (!phase_q) begin
            first_d = sample;
            phase_d = 1'b1;
          end else begin
            phase_d = 1'b0;
            // Unequal pair emits its first sample; a full shifter drops the bit.
            if (first_q != sample && cnt_q != 4'd8) begin
              shift_tmp = {shift_q[6:0], first_q};
              cnt_tmp   = cnt_q + 1'b1;
            end
          end
        end

        shift_d = shift_tmp;
        cnt_d   = cnt_tmp;

        if (cnt_tmp == 4'd8 && (!valid_q || rd_if.rd_ready)) begin
          byte_d  = shift_tmp;
          valid_d = 1'b1;
          cnt_d   = '0;
        end

        if (strobe && rep_next == REP_MAX) begin
          state_d  = ST_FAIL;
          health_d = 1'b1;
          valid_d  = 1'b0;
          shift_d  = '0;
          cnt_d    = '0;
        end
      end

      ST_FAIL: begin
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase

    if (!ena) begin
      state_d  = ST_IDLE;
      warm_d   = '0;
      div_d    = '0;
      rep_d    = '0;
      phase_d  = 1'b0;
      shift_d  = '0;
      cnt_d    = '0;
      valid_d  = 1'b0;
      health_d = 1'b0;
    end
  end

  // State register with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      sync_q   <= '0;
      warm_q   <= '0;
      div_q    <= '0;
      rep_q    <= '0;
      prev_q   <= 1'b0;
      phase_q  <= 1'b0;
      first_q  <= 1'b0;
      shift_q  <= '0;
      cnt_q    <= '0;
      byte_q   <= '0;
      valid_q  <= 1'b0;
      health_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      sync_q   <= sync_d;
      warm_q   <= warm_d;
      div_q    <= div_d;
      rep_q    <= rep_d;
      prev_q   <= prev_d;
      phase_q  <= phase_d;
      first_q  <= first_d;
      shift_q  <= shift_d;
      cnt_q    <= cnt_d;
      byte_q   <= byte_d;
      valid_q  <= valid_d;
      health_q <= health_d;
    end
  end

  assign osc_en          = (state_q != ST_IDLE);
  assign health_fail     = health_q;
  assign rd_if.rnd_byte  = byte_q;
  assign rd_if.rnd_valid = valid_q;

endmodule

// File: tb/tb_trng_ctrl.sv
// Directed, self-checking bench for trng_ctrl.
// Expected bytes are queued when their bits are driven and are checked when
// the DUT hands them over (rnd_valid & rd_ready). Inputs change 1 time unit
// after each rising edge, and outputs are read at that point or on the
// falling edge.
module tb_trng_ctrl;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       ena;
  logic       osc_raw;
  logic [7:0] sample_div;
  logic       osc_en;
  logic       health_fail;

  trng_ctrl_if rd_if ();

  trng_ctrl #(
    .DIV_W(8),
    .REP_LIMIT(32),
    .WARMUP(64)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .ena(ena),
    .osc_raw(osc_raw),
    .sample_div(sample_div),
    .osc_en(osc_en),
    .health_fail(health_fail),
    .rd_if(rd_if.master)
  );

  always #5 clk = ~clk;

  int         n_checks = 0;
  int         n_fails  = 0;
  logic [7:0] exp_q[$];
  logic [7:0] mon_exp;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Drive one raw oscillator value and advance one cycle.
  task automatic applyStimulus(input logic b);
    osc_raw = b;
    tick();
  endtask

  task automatic checkOutput(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_fails++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One debiased bit as a raw sample pair: 1 -> "10", 0 -> "01".
  task automatic send_bit(input logic b);
    applyStimulus(b);
    applyStimulus(~b);
  endtask

  task automatic send_byte(input logic [7:0] v);
    for (int i = 7; i >= 0; i--) send_bit(v[i]);
  endtask

  // Equal pairs 00/11 keep sampling alive without emitting bits.
  task automatic fill(input int n);
    for (int j = 0; j < n; j++) begin
      applyStimulus(j[0]);
      applyStimulus(j[0]);
    end
  endtask

  // From IDLE: enable and stop right after the edge where the raw input is
  // captured for the first RUN sample (62 edges after the enable edge).
  task automatic start_run(input logic [7:0] sd);
    sample_div = sd;
    ena = 1'b1;
    tick();
    repeat (62) tick();
  endtask

  task automatic stop_run();
    ena = 1'b0;
    tick();
  endtask

  // Scoreboard: every handshake must match the oldest queued byte.
  always @(negedge clk) begin
    if (rst_n === 1'b1 && rd_if.rnd_valid === 1'b1 && rd_if.rd_ready === 1'b1) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        n_fails++;
        $error("[TB] FAIL unexpected_byte observed=%h expected=none", rd_if.rnd_byte);
      end else begin
        mon_exp = exp_q.pop_front();
        checkOutput("byte", rd_if.rnd_byte, mon_exp);
      end
    end
  end

  initial begin
    int         se[16];
    logic [0:15] smp;
    logic       v;
    logic       found;

    rst_n = 1'b0;
    ena = 1'b1;
    osc_raw = 1'b0;
    sample_div = 8'd0;
    rd_if.rd_ready = 1'b1;

    // Reset held with activity on the inputs.
    repeat (3) begin
      osc_raw = ~osc_raw;
      tick();
    end
    checkOutput("rst_osc_en", {7'd0, osc_en}, 8'h00);
    checkOutput("rst_valid", {7'd0, rd_if.rnd_valid}, 8'h00);
    checkOutput("rst_byte", rd_if.rnd_byte, 8'h00);
    checkOutput("rst_health", {7'd0, health_fail}, 8'h00);

    // Release: oscillator enabled on the first edge, samples land exactly
    // WARMUP cycles later, so the debias byte only matches with correct timing.
    rst_n = 1'b1;
    tick();
    checkOutput("release_osc_en", {7'd0, osc_en}, 8'h01);
    repeat (62) tick();
    exp_q.push_back(8'h4D);
    begin
      logic [0:19] seq;
      seq = 20'b01_10_00_11_01_01_10_10_01_10;
      for (int i = 0; i < 20; i++) applyStimulus(seq[i]);
    end
    fill(4);
    checkOutput("debias_drained", 8'(exp_q.size()), 8'h00);
    checkOutput("debias_valid_low", {7'd0, rd_if.rnd_valid}, 8'h00);
    stop_run();
    checkOutput("idle_osc_en", {7'd0, osc_en}, 8'h00);
    checkOutput("idle_byte_kept", rd_if.rnd_byte, 8'h4D);

    // Backpressure: A held, B parked in shifter, C discarded.
    rd_if.rd_ready = 1'b0;
    start_run(8'd0);
    exp_q.push_back(8'hA5);
    exp_q.push_back(8'h3C);
    send_byte(8'hA5);
    send_byte(8'h3C);
    send_byte(8'hFF);
    fill(4);
    checkOutput("bp_valid", {7'd0, rd_if.rnd_valid}, 8'h01);
    checkOutput("bp_byte", rd_if.rnd_byte, 8'hA5);
    fill(2);
    checkOutput("bp_byte_stable", rd_if.rnd_byte, 8'hA5);
    rd_if.rd_ready = 1'b1;
    fill(2);
    checkOutput("bp_drained", 8'(exp_q.size()), 8'h00);
    checkOutput("bp_valid_low", {7'd0, rd_if.rnd_valid}, 8'h00);
    stop_run();

    // Health trip: 32 identical samples, the 32nd lands on edge 96.
    osc_raw = 1'b1;
    start_run(8'd0);
    repeat (32) applyStimulus(1'b1);
    tick();
    checkOutput("health_31", {7'd0, health_fail}, 8'h00);
    tick();
    checkOutput("health_32", {7'd0, health_fail}, 8'h01);
    repeat (5) tick();
    checkOutput("health_sticky", {7'd0, health_fail}, 8'h01);
    checkOutput("fail_osc_en", {7'd0, osc_en}, 8'h01);
    checkOutput("fail_valid", {7'd0, rd_if.rnd_valid}, 8'h00);
    stop_run();
    checkOutput("health_clear", {7'd0, health_fail}, 8'h00);
    checkOutput("health_idle", {7'd0, osc_en}, 8'h00);
    ena = 1'b1;
    tick();
    checkOutput("reenable_osc_en", {7'd0, osc_en}, 8'h01);
    stop_run();

    // Divider: strobes 68,72,...,100 with period 4, then every 2 after the
    // mid-period change to sample_div=1. Off-strobe inputs are complemented.
    se[0] = 68;
    for (int k = 1; k < 16; k++) se[k] = se[k-1] + ((k <= 8) ? 4 : 2);
    smp = 16'b1001_0110_0110_1001;
    start_run(8'd3);
    exp_q.push_back(8'h96);
    for (int c = 63; c <= 114; c++) begin
      if (c == 98) sample_div = 8'd1;
      v = 1'b0;
      found = 1'b0;
      for (int k = 0; k < 16; k++) begin
        if (!found && se[k] >= c + 2) begin
          found = 1'b1;
          v = (se[k] == c + 2) ? smp[k] : ~smp[k];
        end
      end
      applyStimulus(v);
    end
    checkOutput("div_byte", rd_if.rnd_byte, 8'h96);
    checkOutput("div_valid", {7'd0, rd_if.rnd_valid}, 8'h01);
    tick();
    checkOutput("div_drained", 8'(exp_q.size()), 8'h00);
    stop_run();
    sample_div = 8'd0;

    // Abort after 5 bits and half a pair; restart must start a fresh byte.
    start_run(8'd0);
    repeat (5) send_bit(1'b1);
    applyStimulus(1'b1);
    stop_run();
    checkOutput("abort_osc_en", {7'd0, osc_en}, 8'h00);
    start_run(8'd0);
    exp_q.push_back(8'h0F);
    send_byte(8'h0F);
    fill(4);
    checkOutput("abort_drained", 8'(exp_q.size()), 8'h00);
    stop_run();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
